id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID→EX pipeline register for the 5-stage MIPS core; successor to the fixed-width ID/EX latch.
- Adds stall (hold), flush (bubble insert), a per-stage valid bit and a load-use hazard detector on registered EX-stage state.
- Sits between decode/register-file read and the EX stage.
- Hazard output feeds the IF/ID stall and PC enable.

Parameters:
- XLEN, 32, datapath width of RD1/RD2/SignImm
- RA_W, 5, register address width of Rs/Rt/Rd
- EX_W, 5, EX control bundle width
- MEM_W, 3, MEM control bundle width
- WB_W, 2, WB control bundle width
- MEMREAD_BIT, 0, bit index within MEM bundle that marks a load (MemRead)
- STALL_MAX, 255, saturation value of the stall-run counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold all E-stage registers this cycle
- flush_i  in  1  insert bubble into E stage next cycle
- valid_d  in  1  D-stage instruction valid
- EX_D  in  EX_W  EX control from decode
- MEM_D  in  MEM_W  MEM control from decode
- WB_D  in  WB_W  WB control from decode
- Rs_D, Rt_D, Rd_D  in  RA_W each  decode register addresses
- RD1_D, RD2_D, SignImm_D  in  XLEN each  decode operands
- valid_e  out  1  E-stage instruction valid
- EX_E, MEM_E, WB_E  out  EX_W/MEM_W/WB_W  registered control bundles
- Rs_E, Rt_E, Rd_E  out  RA_W each  registered register addresses
- RD1_E, RD2_E, SignImm_E  out  XLEN each  registered operands
- lu_hazard_o  out  1  load-use hazard: D must stall, E must take bubble
- stall_run_o  out  8  consecutive-stall cycle count, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every registered output goes to 0, including valid_e and stall_run_o. Outputs stay 0 while rst_n is low. First capture happens on the first rising clk edge after deassertion.
- Latency: one cycle D→E.
- Per rising edge, priority is flush_i > stall_i > load.
  - flush_i=1: valid_e←0; EX_E, MEM_E, WB_E←0. Rs/Rt/Rd and data fields are don't-care, but the implementation loads them to 0.
  - stall_i=1 (no flush): all E registers hold.
  - Otherwise: all E registers ← D inputs, valid_e←valid_d.
  - valid_d=0 on load: control bundles are loaded as 0 regardless of EX_D/MEM_D/WB_D, so an invalid op cannot write back.
- lu_hazard_o is combinational from registered E state plus D addresses. It asserts when valid_e && MEM_E[MEMREAD_BIT] && Rt_E≠0 && (Rt_E==Rs_D || Rt_E==Rt_D) && valid_d.
  - Register 0 never causes a hazard.
  - lu_hazard_o is not gated by stall_i or flush_i.
  - The external controller is expected to drive flush_i=1 into E on that cycle; the block does not self-flush.
- stall_run_o:
  - increments by 1 on each edge with stall_i=1 and flush_i=0;
  - saturates at min(STALL_MAX,255);
  - clears to 0 on any edge with stall_i=0 or flush_i=1.
- Simultaneous flush_i and stall_i: flush wins and stall_run_o clears.
- No combinational path from D inputs to E outputs. lu_hazard_o is the only combinational output.

Optional Feature:
- Macro: ID_EX_FWD_SNOOP_EN.
- Defined: adds inputs wb_we_i (1), wb_ra_i (RA_W) and wb_data_i (XLEN).
  - On a load edge, if wb_we_i && wb_ra_i≠0 && wb_ra_i==Rs_D, RD1_E captures wb_data_i instead of RD1_D. The same rule applies to Rt_D/RD2_E.
  - This covers register-file write-then-read in the same cycle.
  - The snoop is not applied on stall (hold) or flush edges.
- Undefined: these ports do not exist. RD1_E/RD2_E always capture RD1_D/RD2_D.

Test Plan:
- Async reset: drive all inputs to 1s, pulse rst_n low mid-cycle → all outputs 0 immediately, before the next edge. After release, the first edge loads inputs with a 1-cycle latency.
- Normal flow: RD1_D=0x1234_5678, EX_D=5'h1A, valid_d=1 → next edge RD1_E=0x1234_5678, EX_E=5'h1A, valid_e=1.
- Stall 3 cycles while D changes to RD1_D=0xDEAD_BEEF → E holds old values; stall_run_o=1,2,3; deassert → loads 0xDEAD_BEEF and stall_run_o=0.
- Flush with stall_i=1 and MEM_D=3'b111 → valid_e=0, MEM_E=0, WB_E=0, stall_run_o=0.
- Load-use: E holds a load with MEM_E[0]=1 and Rt_E=5'd8; D has Rs_D=8 → lu_hazard_o=1. With Rt_E=0 → 0. With valid_e=0 → 0.
- Saturation: hold stall_i=1 for 300 cycles with STALL_MAX=255 → stall_run_o stays at 255 from cycle 255 onward.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with stall/flush/valid, load-use hazard detect and a stall-run counter.
// Latency 1 cycle D->E; stall_i holds E, flush_i (higher priority) inserts a bubble. Option: ID_EX_FWD_SNOOP_EN.
module id_ex_pipe_reg #(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int EX_W        = 5,
  parameter int MEM_W       = 3,
  parameter int WB_W        = 2,
  parameter int MEMREAD_BIT = 0,
  parameter int STALL_MAX   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_d,
  input  logic [EX_W-1:0]   EX_D,
  input  logic [MEM_W-1:0]  MEM_D,
  input  logic [WB_W-1:0]   WB_D,
  input  logic [RA_W-1:0]   Rs_D,
  input  logic [RA_W-1:0]   Rt_D,
  input  logic [RA_W-1:0]   Rd_D,
  input  logic [XLEN-1:0]   RD1_D,
  input  logic [XLEN-1:0]   RD2_D,
  input  logic [XLEN-1:0]   SignImm_D,
`ifdef ID_EX_FWD_SNOOP_EN
  input  logic              wb_we_i,
  input  logic [RA_W-1:0]   wb_ra_i,
  input  logic [XLEN-1:0]   wb_data_i,
`endif
  output logic              valid_e,
  output logic [EX_W-1:0]   EX_E,
  output logic [MEM_W-1:0]  MEM_E,
  output logic [WB_W-1:0]   WB_E,
  output logic [RA_W-1:0]   Rs_E,
  output logic [RA_W-1:0]   Rt_E,
  output logic [RA_W-1:0]   Rd_E,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   SignImm_E,
  output logic              lu_hazard_o,
  output logic [7:0]        stall_run_o
);

  typedef struct packed {
    logic             valid;
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
  } e_stage_t;

  localparam logic [7:0] STALL_SAT = (STALL_MAX > 255) ? 8'd255 : 8'(STALL_MAX);

  e_stage_t        e_q;
  e_stage_t        e_d;
  logic [7:0]      stall_run_q;
  logic [7:0]      stall_run_d;
  logic [XLEN-1:0] rd1_load;
  logic [XLEN-1:0] rd2_load;

  // Same-cycle register-file write is not yet visible on RD1_D/RD2_D; take it from the WB bus.
`ifdef ID_EX_FWD_SNOOP_EN
  always_comb begin
    rd1_load = RD1_D;
    rd2_load = RD2_D;
    if (wb_we_i && (wb_ra_i != '0) && (wb_ra_i == Rs_D)) rd1_load = wb_data_i;
    if (wb_we_i && (wb_ra_i != '0) && (wb_ra_i == Rt_D)) rd2_load = wb_data_i;
  end
`else
  always_comb begin
    rd1_load = RD1_D;
    rd2_load = RD2_D;
  end
`endif

  always_comb begin
    e_d = e_q;
    if (flush_i) begin
      e_d = '0;
    end else if (!stall_i) begin
      e_d.valid = valid_d;
      // An invalid op carries no control so it can never write memory or the register file.
      e_d.ex    = valid_d ? EX_D  : '0;
      e_d.mem   = valid_d ? MEM_D : '0;
      e_d.wb    = valid_d ? WB_D  : '0;
      e_d.rs    = Rs_D;
      e_d.rt    = Rt_D;
      e_d.rd    = Rd_D;
      e_d.rd1   = rd1_load;
      e_d.rd2   = rd2_load;
      e_d.imm   = SignImm_D;
    end
  end

  always_comb begin
    stall_run_d = 8'd0;
    if (stall_i && !flush_i) begin
      stall_run_d = (stall_run_q >= STALL_SAT) ? STALL_SAT : stall_run_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= '0;
      stall_run_q <= 8'd0;
    end else begin
      e_q         <= e_d;
      stall_run_q <= stall_run_d;
    end
  end

  assign valid_e     = e_q.valid;
  assign EX_E        = e_q.ex;
  assign MEM_E       = e_q.mem;
  assign WB_E        = e_q.wb;
  assign Rs_E        = e_q.rs;
  assign Rt_E        = e_q.rt;
  assign Rd_E        = e_q.rd;
  assign RD1_E       = e_q.rd1;
  assign RD2_E       = e_q.rd2;
  assign SignImm_E   = e_q.imm;
  assign stall_run_o = stall_run_q;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign lu_hazard_o = e_q.valid && e_q.mem[MEMREAD_BIT] && (e_q.rt != '0) &&
                       ((e_q.rt == Rs_D) || (e_q.rt == Rt_D)) && valid_d;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (default build, snoop option off).
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, valid_d;
  logic [4:0]  EX_D;
  logic [2:0]  MEM_D;
  logic [1:0]  WB_D;
  logic [4:0]  Rs_D, Rt_D, Rd_D;
  logic [31:0] RD1_D, RD2_D, SignImm_D;
  logic        valid_e;
  logic [4:0]  EX_E;
  logic [2:0]  MEM_E;
  logic [1:0]  WB_E;
  logic [4:0]  Rs_E, Rt_E, Rd_E;
  logic [31:0] RD1_E, RD2_E, SignImm_E;
  logic        lu_hazard_o;
  logic [7:0]  stall_run_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_d(valid_d),
    .EX_D(EX_D), .MEM_D(MEM_D), .WB_D(WB_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .valid_e(valid_e), .EX_E(EX_E), .MEM_E(MEM_E), .WB_E(WB_E),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .SignImm_E(SignImm_E), .lu_hazard_o(lu_hazard_o), .stall_run_o(stall_run_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_d = 1'b0;
    EX_D = '0; MEM_D = '0; WB_D = '0; Rs_D = '0; Rt_D = '0; Rd_D = '0;
    RD1_D = '0; RD2_D = '0; SignImm_D = '0;
    tick(); tick();
    check("rst_valid", valid_e, 0);
    check("rst_rd1", RD1_E, 0);
    check("rst_run", stall_run_o, 0);

    // All-ones inputs, release reset mid-cycle, first edge loads
    valid_d = 1'b1; EX_D = '1; MEM_D = '1; WB_D = '1; Rs_D = '1; Rt_D = '1; Rd_D = '1;
    RD1_D = '1; RD2_D = '1; SignImm_D = '1;
    #2 rst_n = 1'b1;
    check("rst_hold_valid", valid_e, 0);
    tick();
    check("ld1_valid", valid_e, 1);
    check("ld1_rd1", RD1_E, 32'hFFFF_FFFF);
    check("ld1_ex", EX_E, 5'h1F);
    check("ld1_mem", MEM_E, 3'h7);
    check("ld1_rt", Rt_E, 5'h1F);
    check("ld1_haz", lu_hazard_o, 1);

    // Async reset pulse mid-cycle clears before any edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid_e, 0);
    check("arst_rd1", RD1_E, 0);
    check("arst_ex", EX_E, 0);
    check("arst_mem", MEM_E, 0);
    check("arst_imm", SignImm_E, 0);
    check("arst_haz", lu_hazard_o, 0);
    tick();
    check("arst_low_edge", valid_e, 0);
    #2 rst_n = 1'b1;
    tick();
    check("rel_valid", valid_e, 1);
    check("rel_rd2", RD2_E, 32'hFFFF_FFFF);

    // Normal flow
    RD1_D = 32'h1234_5678; RD2_D = 32'hA5A5_A5A5; SignImm_D = 32'hFFFF_FFF0;
    EX_D = 5'h1A; MEM_D = 3'b000; WB_D = 2'b10; Rs_D = 5'd1; Rt_D = 5'd2; Rd_D = 5'd3;
    valid_d = 1'b1;
    tick();
    check("nf_rd1", RD1_E, 32'h1234_5678);
    check("nf_rd2", RD2_E, 32'hA5A5_A5A5);
    check("nf_imm", SignImm_E, 32'hFFFF_FFF0);
    check("nf_ex", EX_E, 5'h1A);
    check("nf_wb", WB_E, 2'b10);
    check("nf_rs", Rs_E, 5'd1);
    check("nf_rd", Rd_E, 5'd3);
    check("nf_valid", valid_e, 1);
    check("nf_haz", lu_hazard_o, 0);

    // Stall for 3 cycles while D changes
    stall_i = 1'b1; RD1_D = 32'hDEAD_BEEF; EX_D = 5'h05;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("st_rd1", RD1_E, 32'h1234_5678);
      check("st_ex", EX_E, 5'h1A);
      check("st_run", stall_run_o, i);
    end
    stall_i = 1'b0;
    tick();
    check("st_rel_rd1", RD1_E, 32'hDEAD_BEEF);
    check("st_rel_ex", EX_E, 5'h05);
    check("st_rel_run", stall_run_o, 0);

    // Flush beats stall
    stall_i = 1'b1;
    tick();
    check("pre_fl_run", stall_run_o, 1);
    flush_i = 1'b1; MEM_D = 3'b111; WB_D = 2'b11;
    tick();
    check("fl_valid", valid_e, 0);
    check("fl_mem", MEM_E, 0);
    check("fl_wb", WB_E, 0);
    check("fl_ex", EX_E, 0);
    check("fl_rd1", RD1_E, 0);
    check("fl_run", stall_run_o, 0);
    flush_i = 1'b0; stall_i = 1'b0;

    // Invalid op loads zero control but keeps data
    valid_d = 1'b0; EX_D = 5'h1F; MEM_D = 3'b111; WB_D = 2'b11; RD1_D = 32'h55;
    tick();
    check("inv_valid", valid_e, 0);
    check("inv_ex", EX_E, 0);
    check("inv_mem", MEM_E, 0);
    check("inv_wb", WB_E, 0);
    check("inv_rd1", RD1_E, 32'h55);

    // Load-use hazard
    valid_d = 1'b1; MEM_D = 3'b001; Rs_D = 5'd4; Rt_D = 5'd8;
    tick();
    Rs_D = 5'd8; Rt_D = 5'd9; MEM_D = 3'b000;
    #1 check("lu_rs", lu_hazard_o, 1);
    Rs_D = 5'd3; Rt_D = 5'd8;
    #1 check("lu_rt", lu_hazard_o, 1);
    Rt_D = 5'd9;
    #1 check("lu_nomatch", lu_hazard_o, 0);
    Rs_D = 5'd8; valid_d = 1'b0;
    #1 check("lu_dinv", lu_hazard_o, 0);
    valid_d = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    #1 check("lu_ungated", lu_hazard_o, 1);
    stall_i = 1'b0; flush_i = 1'b0;

    MEM_D = 3'b001; Rs_D = 5'd0; Rt_D = 5'd0;
    tick();
    #1 check("lu_r0", lu_hazard_o, 0);

    Rt_D = 5'd8; valid_d = 1'b0;
    tick();
    Rs_D = 5'd8; valid_d = 1'b1;
    #1 check("lu_einv", lu_hazard_o, 0);

    // Saturation of the stall-run counter
    stall_i = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      check("sat_run", stall_run_o, (i > 255) ? 255 : i);
    end
    stall_i = 1'b0;
    tick();
    check("sat_clear", stall_run_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
